// File: rtl/picorv_stream_pkg.sv
// Shared constants for the RISC-V tile stream ports: default word width,
// memory-mapped offsets and STATUS register layout.
package picorv_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [31:0] STREAM_DATA_OFFSET   = 32'h0;
  localparam logic [31:0] STREAM_STATUS_OFFSET = 32'h4;

  localparam int STATUS_AVAIL_BIT     = 0;
  localparam int STATUS_UNDERFLOW_BIT = 1;
  localparam int STATUS_COUNT_LSB     = 8;
  localparam int STATUS_COUNT_MSB     = 15;

  // Assembles the STATUS word as the core sees it when polling the port.
  function automatic logic [31:0] pack_status(input logic       avail,
                                              input logic       underflow,
                                              input logic [7:0] count);
    logic [31:0] word;
    word                                        = '0;
    word[STATUS_AVAIL_BIT]                      = avail;
    word[STATUS_UNDERFLOW_BIT]                  = underflow;
    word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]     = count;
    return word;
  endfunction

endpackage

// File: rtl/producer2riscv_if.sv
// Upstream valid/ready stream plus the memory-decoder pop/response bundle.
interface producer2riscv_if #(
  parameter int DATA_WIDTH = picorv_stream_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
);

  logic [DATA_WIDTH-1:0] din;
  logic                  val_in;
  logic                  ready_upward;
  logic                  rd_req;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_avail;
  logic [CNT_W-1:0]      count;
  logic                  underflow;
  logic                  clr_underflow;

  modport slave (
    input  din, val_in, rd_req, clr_underflow,
    output ready_upward, rd_ack, rd_data, rd_avail, count, underflow
  );

  modport master (
    output din, val_in, rd_req, clr_underflow,
    input  ready_upward, rd_ack, rd_data, rd_avail, count, underflow
  );

endinterface

// File: rtl/stream_fifo_ram.sv
// FIFO storage: one write port and a registered read port whose output
// register can be synchronously cleared (reset or underflowing pop).
module stream_fifo_ram #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data_d = rd_data_q;
    if (clr) begin
      rd_data_d = '0;
    end else if (re) begin
      rd_data_d = mem_q[raddr];
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/producer2riscv.sv
// Inbound stream port: buffers producer words in a small FIFO and answers
// one-cycle pop requests from the memory decoder with a registered response.
module producer2riscv
  import picorv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset,
  producer2riscv_if.slave bus
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             rd_ack_d, rd_ack_q;
  logic             underflow_d, underflow_q;

  logic ready;
  logic empty;
  logic push;
  logic pop_ok;
  logic pop_empty;

  // No bypass: a full FIFO stays not-ready even when a pop lands in the same cycle.
  assign ready     = !reset && (count_q != CNT_FULL);
  assign empty     = (count_q == '0);
  assign push      = bus.val_in && ready;
  assign pop_ok    = bus.rd_req && !empty;
  assign pop_empty = bus.rd_req && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_ack_d    = bus.rd_req;
    underflow_d = underflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clearing wins over a same-cycle underflowing pop.
    if (bus.clr_underflow) begin
      underflow_d = 1'b0;
    end else if (pop_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_ack_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_ack_q    <= rd_ack_d;
      underflow_q <= underflow_d;
    end
  end

  stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.din),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .clr   (reset || pop_empty),
    .rdata (bus.rd_data)
  );

  assign bus.ready_upward = ready;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_avail     = !empty;
  assign bus.count        = count_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_producer2riscv.sv
// Directed bench for producer2riscv: reset, fill, drain, underflow,
// simultaneous push/pop, pointer wrap and mid-transfer reset.
module tb_producer2riscv;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic reset;

  int n_checks;
  int n_pass;

  producer2riscv_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  producer2riscv #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.val_in        = 1'b0;
    bus.rd_req        = 1'b0;
    bus.clr_underflow = 1'b0;
    bus.din           = '0;
  endtask

  initial begin
    logic [31:0] words [10];

    n_checks = 0;
    n_pass   = 0;

    // Reset held three cycles with a word offered on val_in.
    reset             = 1'b1;
    bus.din           = 32'h99;
    bus.val_in        = 1'b1;
    bus.rd_req        = 1'b0;
    bus.clr_underflow = 1'b0;
    repeat (3) tick();
    check("reset_ready",     32'(bus.ready_upward), 32'd0);
    check("reset_count",     32'(bus.count),        32'd0);
    check("reset_rd_ack",    32'(bus.rd_ack),       32'd0);
    check("reset_rd_data",   bus.rd_data,           32'd0);
    check("reset_underflow", 32'(bus.underflow),    32'd0);
    check("reset_rd_avail",  32'(bus.rd_avail),     32'd0);

    idle_inputs();
    reset = 1'b0;
    #1;
    check("release_ready", 32'(bus.ready_upward), 32'd1);
    tick();
    check("release_count", 32'(bus.count), 32'd0);

    // Fill to DEPTH, then hold a fifth word that must not be taken.
    for (int i = 0; i < DEPTH; i++) begin
      bus.din    = 32'h11 * (i + 1);
      bus.val_in = 1'b1;
      tick();
      check("fill_count", 32'(bus.count), 32'(i + 1));
    end
    check("full_ready", 32'(bus.ready_upward), 32'd0);
    bus.din = 32'h55;
    tick();
    check("full_hold_count", 32'(bus.count),        32'd4);
    check("full_hold_ready", 32'(bus.ready_upward), 32'd0);
    bus.val_in = 1'b0;

    // Four back-to-back pops.
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_req = 1'b1;
      tick();
      check("drain_ack",  32'(bus.rd_ack), 32'd1);
      check("drain_data", bus.rd_data,     32'h11 * (i + 1));
    end
    bus.rd_req = 1'b0;
    tick();
    check("drain_ack_drop",  32'(bus.rd_ack),    32'd0);
    check("drain_data_hold", bus.rd_data,        32'h44);
    check("drain_count",     32'(bus.count),     32'd0);
    check("drain_avail",     32'(bus.rd_avail),  32'd0);
    check("drain_underflow", 32'(bus.underflow), 32'd0);

    // Pop from empty: zero data, sticky underflow, then clear.
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("uf_ack",  32'(bus.rd_ack),    32'd1);
    check("uf_data", bus.rd_data,        32'd0);
    check("uf_flag", 32'(bus.underflow), 32'd1);
    tick();
    check("uf_ack_drop", 32'(bus.rd_ack),    32'd0);
    check("uf_sticky",   32'(bus.underflow), 32'd1);
    bus.clr_underflow = 1'b1;
    tick();
    check("uf_clear", 32'(bus.underflow), 32'd0);

    // Clear takes priority over a same-cycle underflowing pop.
    bus.rd_req = 1'b1;
    tick();
    idle_inputs();
    check("uf_clr_prio_ack",  32'(bus.rd_ack),    32'd1);
    check("uf_clr_prio_flag", 32'(bus.underflow), 32'd0);

    // count=2, push and pop together: count holds, head returned.
    bus.val_in = 1'b1;
    bus.din    = 32'hA1;
    tick();
    bus.din    = 32'hA2;
    tick();
    check("sim_pre_count", 32'(bus.count), 32'd2);
    bus.din    = 32'hAA;
    bus.rd_req = 1'b1;
    tick();
    bus.val_in = 1'b0;
    check("sim_count", 32'(bus.count), 32'd2);
    check("sim_ack",   32'(bus.rd_ack), 32'd1);
    check("sim_data",  bus.rd_data,     32'hA1);
    tick();
    check("sim_pop2", bus.rd_data, 32'hA2);
    tick();
    bus.rd_req = 1'b0;
    check("sim_pop3",   bus.rd_data,    32'hAA);
    check("sim_empty",  32'(bus.count), 32'd0);

    // Push and pop while empty: underflow, word stored, no fall-through.
    bus.val_in = 1'b1;
    bus.din    = 32'hAA;
    bus.rd_req = 1'b1;
    tick();
    bus.val_in = 1'b0;
    check("ef_ack",   32'(bus.rd_ack),    32'd1);
    check("ef_data",  bus.rd_data,        32'd0);
    check("ef_flag",  32'(bus.underflow), 32'd1);
    check("ef_count", 32'(bus.count),     32'd1);
    bus.clr_underflow = 1'b1;
    tick();
    idle_inputs();
    check("ef_stored", bus.rd_data,        32'hAA);
    check("ef_clear",  32'(bus.underflow), 32'd0);

    // Full plus pop: no bypass, so only the pop happens.
    for (int i = 0; i < DEPTH; i++) begin
      bus.val_in = 1'b1;
      bus.din    = 32'hC0 + i;
      tick();
    end
    bus.din    = 32'h77;
    bus.rd_req = 1'b1;
    tick();
    idle_inputs();
    check("full_pop_count", 32'(bus.count), 32'd3);
    check("full_pop_data",  bus.rd_data,    32'hC0);
    bus.rd_req = 1'b1;
    repeat (3) tick();
    bus.rd_req = 1'b0;
    check("full_pop_last",  bus.rd_data,    32'hC3);
    check("full_pop_empty", 32'(bus.count), 32'd0);

    // Continuous streaming of 10 words; pointers wrap twice.
    for (int i = 0; i < 10; i++) words[i] = 32'h100 + 32'(i * 7);
    for (int c = 0; c <= 10; c++) begin
      bus.val_in = (c < 10);
      bus.din    = (c < 10) ? words[c] : 32'h0;
      bus.rd_req = (c >= 1);
      tick();
      if (c >= 1) begin
        check("wrap_ack",  32'(bus.rd_ack), 32'd1);
        check("wrap_data", bus.rd_data,     words[c-1]);
      end
    end
    idle_inputs();
    tick();
    check("wrap_count", 32'(bus.count), 32'd0);

    // Reset with three words buffered and a pop pending.
    bus.val_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.din = 32'hD0 + i;
      tick();
    end
    bus.val_in = 1'b0;
    check("mid_pre_count", 32'(bus.count), 32'd3);
    bus.rd_req = 1'b1;
    reset      = 1'b1;
    tick();
    check("mid_rst_ack",   32'(bus.rd_ack),       32'd0);
    check("mid_rst_count", 32'(bus.count),        32'd0);
    check("mid_rst_ready", 32'(bus.ready_upward), 32'd0);
    bus.rd_req = 1'b0;
    reset      = 1'b0;
    tick();
    check("mid_post_ack",   32'(bus.rd_ack),   32'd0);
    check("mid_post_data",  bus.rd_data,       32'd0);
    check("mid_post_avail", 32'(bus.rd_avail), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/producer2riscv.md
# producer2riscv

Inbound stream port for the RISC-V tile, running opposite to riscv2consumer. It accepts words from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. The memory decoder in picorv_mem drains it with one-cycle read requests, each answered with a registered read response. It sits between a tile input (`din`/`val_in`/`ready_upward`) and the core's load path.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream word width.
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1: width of `count`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `din`, in, DATA_WIDTH: upstream data.
- `val_in`, in, 1: upstream valid.
- `ready_upward`, out, 1: FIFO can accept a word.
- `rd_req`, in, 1: one-cycle pop request from the memory decoder (core load of the data address).
- `rd_ack`, out, 1: response strobe, one cycle after `rd_req`.
- `rd_data`, out, DATA_WIDTH: popped word, valid while `rd_ack`=1.
- `rd_avail`, out, 1: FIFO non-empty (status bit for polling).
- `count`, out, CNT_W: current occupancy, 0..DEPTH.
- `underflow`, out, 1: sticky flag, set by a pop from an empty FIFO.
- `clr_underflow`, in, 1: clears `underflow`.

## Operation
- **Push.** `val_in && ready_upward` at a rising edge writes `din` at the write pointer and advances it. The pointer wraps modulo DEPTH.
- **Ready.** `ready_upward = !reset && (count != DEPTH)`. There is no bypass: when full, a simultaneous pop does not make room in the same cycle.
- **Pop.**
  - `rd_req` with count>0: read pointer advances (wrapping), `rd_data` gets the head word, `rd_ack`=1 next cycle.
  - `rd_req` with count==0: `rd_data` gets 0, `rd_ack`=1 next cycle, `underflow` is set, pointers are unchanged.
- **Simultaneous push and pop.**
  - Non-empty and not full: count is unchanged, both pointers advance.
  - Empty: the pop underflows and returns 0. The pushed word is stored and count becomes 1. There is no fall-through.
- **Count.** `count` is +1 on push only, −1 on valid pop only, and unchanged otherwise. It never exceeds DEPTH or drops below 0.
- **rd_avail.** `rd_avail = (count != 0)`.
- **Underflow clear.** `clr_underflow` has priority over a same-cycle set: the flag clears.
- **rd_req pacing.** Back-to-back `rd_req` on consecutive cycles is legal. Each produces its own `rd_ack` one cycle later.
- **Reset.** `reset` has priority over everything. Mid-transfer it discards FIFO contents, and any in-flight `rd_ack` is dropped.

## Timing
- Reset values:
  - `count`, `rd_ack`, `rd_data`, `underflow`, `rd_avail`, pointers = 0.
  - `ready_upward` = 0 while `reset` is high and 1 on the first cycle after release.
- Push-to-visible latency:
  - A word accepted at edge N is counted in `count`/`rd_avail` after edge N.
  - An `rd_req` sampled at edge N+1 returns that word.
- Pop latency: `rd_req` sampled at edge N gives `rd_ack` and `rd_data` registered at edge N, observed during cycle N+1.
- `rd_ack` is a single-cycle pulse per request.
- `rd_data` holds its last value until the next ack.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Structure
- Shared package `picorv_stream_pkg` holds:
  - the default DATA_WIDTH;
  - stream-port address offsets (DATA=0x0, STATUS=0x4);
  - the STATUS bit positions: bit0 `rd_avail`, bit1 `underflow`, bits[15:8] `count`.
- Storage array goes in sub-module `stream_fifo_ram`: DEPTH×DATA_WIDTH, one write port, registered read.
- Pointers, count, flags and the response register live in `producer2riscv`.

## Test plan
1. **Reset:** hold `reset` 3 cycles with `val_in`=1 → `ready_upward`=0, count=0, no push. After release `ready_upward`=1.
2. **Fill:** push 0x11,0x22,0x33,0x44 on consecutive cycles with DEPTH=4 → count=4, `ready_upward`=0. A fifth word, 0x55, held on `val_in` is not accepted.
3. **Drain:** four back-to-back `rd_req` → `rd_ack` on four consecutive cycles returning 0x11,0x22,0x33,0x44. Then count=0, `rd_avail`=0, `underflow`=0.
4. **Underflow:** `rd_req` on empty → `rd_ack`=1, `rd_data`=0, `underflow`=1 sticky. Then `clr_underflow` → `underflow`=0.
5. **Simultaneous traffic:** count=2, push 0xAA and pop on the same cycle → count stays 2 and the head is returned. Push while empty plus pop → underflow, and count=1 with 0xAA stored.
6. **Wrap and mid-reset:** push/pop 10 words continuously (pointers wrap twice) → in-order data. Then assert `reset` while count=3 → count=0 and no `rd_ack` issued for the pending request.
